// File: rtl/lift_pkg.sv
// Shared definitions for the 5/3 lifting-step sample store: sequencer
// states, rounding constants and default geometry.
package lift_pkg;

  localparam int DEF_W  = 17;
  localparam int DEF_AW = 8;

  localparam int PRED_SHIFT = 1;
  localparam int UPD_OFFSET = 2;
  localparam int UPD_SHIFT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_L = 3'd1,
    ST_RD_C = 3'd2,
    ST_RD_R = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } lift_state_e;

endpackage

// File: rtl/lift_ram_sp.sv
// Single-port synchronous-read RAM; read returns the pre-write contents.
module lift_ram_sp #(
  parameter int W  = 17,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  q
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem_r [DEPTH];
  logic [W-1:0] q_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    q_r <= mem_r[addr];
  end

  assign q = q_r;

endmodule

// File: rtl/lift_step_ram.sv
// Sample line store with an in-place 5/3 predict/update sequencer that
// generates its own symmetric-extension neighbour addressing.
module lift_step_ram
  import lift_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_we,
  input  logic [AW-1:0] pix_addr,
  input  logic [W-1:0]  pix_din,
  output logic [W-1:0]  pix_dout,
  input  logic          pix_even_odd,
  input  logic          pix_fwd_inv,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] LEN_MIN = (AW+1)'(2);
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  lift_state_e state_r;
  logic [AW-1:0] idx_r;
  logic [AW:0]   len_r;
  logic          even_odd_r;
  logic          fwd_inv_r;
  logic [W-1:0]  l_r;
  logic [W-1:0]  c_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          host_rd_r;
  logic [W-1:0]  pix_dout_r;

  logic          len_ok_s;
  logic          more_s;
  logic          right_edge_s;
  logic [AW-1:0] addr_l_s;
  logic [AW-1:0] addr_r_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic [W-1:0]  ram_din_s;
  logic [W-1:0]  ram_q_s;

  logic signed [W+1:0] l_ext_s;
  logic signed [W+1:0] r_ext_s;
  logic signed [W+1:0] c_ext_s;
  logic signed [W+1:0] sum_s;
  logic signed [W+1:0] pred_s;
  logic signed [W+1:0] upd_s;
  logic signed [W+1:0] res_s;

  lift_ram_sp #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .q    (ram_q_s)
  );

  assign len_ok_s     = (len >= LEN_MIN) && (len <= LEN_MAX);
  assign more_s       = (({1'b0, idx_r} + (AW+1)'(2)) < len_r);
  assign right_edge_s = (({1'b0, idx_r} + (AW+1)'(1)) >= len_r);

  // Symmetric boundary extension: mirror the missing neighbour
  always_comb begin
    addr_l_s = idx_r - AW'(1);
    addr_r_s = idx_r + AW'(1);
    if (idx_r == AW'(0)) begin
      addr_l_s = idx_r + AW'(1);
    end else begin
      addr_l_s = idx_r - AW'(1);
    end
    if (right_edge_s) begin
      addr_r_s = idx_r - AW'(1);
    end else begin
      addr_r_s = idx_r + AW'(1);
    end
  end

  // RAM port mux: host while idle, sequencer otherwise
  always_comb begin
    ram_addr_s = pix_addr;
    ram_we_s   = 1'b0;
    ram_din_s  = pix_din;
    case (state_r)
      ST_IDLE: begin
        ram_addr_s = pix_addr;
        ram_we_s   = pix_we;
        ram_din_s  = pix_din;
      end
      ST_RD_L: ram_addr_s = addr_l_s;
      ST_RD_C: ram_addr_s = idx_r;
      ST_RD_R: ram_addr_s = addr_r_s;
      ST_WR: begin
        ram_addr_s = idx_r;
        ram_we_s   = 1'b1;
        ram_din_s  = W'(res_s);
      end
      ST_DONE: ram_addr_s = idx_r;
      default: begin
        ram_addr_s = pix_addr;
        ram_we_s   = 1'b0;
        ram_din_s  = pix_din;
      end
    endcase
  end

  // Lifting arithmetic; R is the live RAM output during WR
  always_comb begin
    l_ext_s = {{2{l_r[W-1]}}, l_r};
    r_ext_s = {{2{ram_q_s[W-1]}}, ram_q_s};
    c_ext_s = {{2{c_r[W-1]}}, c_r};
    sum_s   = l_ext_s + r_ext_s;
    pred_s  = sum_s >>> PRED_SHIFT;
    upd_s   = (sum_s + (W+2)'(UPD_OFFSET)) >>> UPD_SHIFT;
    case ({even_odd_r, fwd_inv_r})
      2'b00:   res_s = c_ext_s + pred_s;
      2'b01:   res_s = c_ext_s - pred_s;
      2'b10:   res_s = c_ext_s - upd_s;
      2'b11:   res_s = c_ext_s + upd_s;
      default: res_s = c_ext_s;
    endcase
  end

  // Step sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      len_r      <= '0;
      even_odd_r <= 1'b0;
      fwd_inv_r  <= 1'b0;
      l_r        <= '0;
      c_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && len_ok_s) begin
            len_r      <= len;
            even_odd_r <= pix_even_odd;
            fwd_inv_r  <= pix_fwd_inv;
            idx_r      <= pix_even_odd ? AW'(0) : AW'(1);
            busy_r     <= 1'b1;
            state_r    <= ST_RD_L;
          end else if (start) begin
            err_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RD_L: state_r <= ST_RD_C;
        ST_RD_C: begin
          l_r     <= ram_q_s;
          state_r <= ST_RD_R;
        end
        ST_RD_R: begin
          c_r     <= ram_q_s;
          state_r <= ST_WR;
        end
        ST_WR: begin
          if (more_s) begin
            idx_r   <= idx_r + AW'(2);
            state_r <= ST_RD_L;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Host read data: only refreshed from host-owned RAM cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rd_r  <= 1'b0;
      pix_dout_r <= '0;
    end else begin
      host_rd_r <= (state_r == ST_IDLE);
      if (host_rd_r) begin
        pix_dout_r <= ram_q_s;
      end else begin
        pix_dout_r <= pix_dout_r;
      end
    end
  end

  assign pix_dout = pix_dout_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_lift_step_ram.sv
// Directed self-checking bench for lift_step_ram: 5/3 forward/inverse steps,
// boundary handling, rejected starts and mid-step reset.
module tb_lift_step_ram;

  localparam int W  = 17;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [W-1:0]  pix_din;
  logic [W-1:0]  pix_dout;
  logic          pix_even_odd;
  logic          pix_fwd_inv;
  logic [AW:0]   len;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  lift_step_ram #(.W(W), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_we       (pix_we),
    .pix_addr     (pix_addr),
    .pix_din      (pix_din),
    .pix_dout     (pix_dout),
    .pix_even_odd (pix_even_odd),
    .pix_fwd_inv  (pix_fwd_inv),
    .len          (len),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int a, input int d);
    @(negedge clk);
    pix_we   = 1'b1;
    pix_addr = AW'(a);
    pix_din  = W'(d);
    @(negedge clk);
    pix_we   = 1'b0;
  endtask

  task automatic host_read(input int a, output int v);
    @(negedge clk);
    pix_addr = AW'(a);
    @(posedge clk);
    @(posedge clk);
    #1;
    v = int'($signed(pix_dout));
  endtask

  task automatic check_line(input string tag, input int exp [8]);
    int v;
    for (int i = 0; i < 8; i++) begin
      host_read(i, v);
      check_eq($sformatf("%s_x%0d", tag, i), v, exp[i]);
    end
  endtask

  // Start a step; optionally write on the start cycle or disturb inputs mid-run
  task automatic run_step(input logic eo, input logic fi, input int ln,
                          input logic we_at_start, input int wa, input int wd,
                          input logic disturb, output int cyc);
    int seen;
    int err_seen;
    @(negedge clk);
    pix_even_odd = eo;
    pix_fwd_inv  = fi;
    len          = (AW+1)'(ln);
    start        = 1'b1;
    pix_we       = we_at_start;
    pix_addr     = AW'(wa);
    pix_din      = W'(wd);
    @(posedge clk);
    #1;
    start  = 1'b0;
    pix_we = 1'b0;
    check_eq("busy_after_start", int'(busy), 1);
    cyc      = 0;
    seen     = 0;
    err_seen = 0;
    while (cyc < 200 && seen == 0) begin
      if (disturb && cyc == 3) begin
        start        = 1'b1;
        pix_we       = 1'b1;
        pix_addr     = AW'(1);
        pix_din      = W'(999);
        pix_fwd_inv  = ~fi;
        pix_even_odd = ~eo;
        len          = (AW+1)'(2);
      end else begin
        start  = 1'b0;
        pix_we = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (err) err_seen++;
      if (done) seen = 1;
    end
    start  = 1'b0;
    pix_we = 1'b0;
    if (seen == 0) check_eq("done_timeout", 0, 1);
    check_eq("busy_at_done", int'(busy), 0);
    if (disturb) check_eq("no_err_while_busy", err_seen, 0);
  endtask

  initial begin
    int cyc;
    int v;
    int dcount;
    int ramp [8]   = '{0, 10, 20, 30, 40, 50, 60, 70};
    int exp_odd [8] = '{0, 0, 20, 0, 40, 0, 60, 10};
    int exp_evn [8] = '{0, 0, 20, 0, 40, 0, 63, 10};

    rst_n        = 1'b0;
    pix_we       = 1'b0;
    pix_addr     = '0;
    pix_din      = '0;
    pix_even_odd = 1'b0;
    pix_fwd_inv  = 1'b0;
    len          = '0;
    start        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_dout", int'(pix_dout), 0);
    rst_n = 1'b1;

    // Forward predict then update on a ramp
    for (int i = 0; i < 8; i++) host_write(i, 10 * i);
    run_step(1'b0, 1'b1, 8, 1'b0, 0, 0, 1'b0, cyc);
    check_eq("odd_fwd_latency", cyc, 17);
    check_line("odd_fwd", exp_odd);

    run_step(1'b1, 1'b1, 8, 1'b0, 0, 0, 1'b1, cyc);
    check_eq("even_fwd_latency", cyc, 17);
    check_line("even_fwd", exp_evn);

    // Inverse update then inverse predict restores the ramp
    run_step(1'b1, 1'b0, 8, 1'b0, 0, 0, 1'b0, cyc);
    check_line("even_inv", exp_odd);
    run_step(1'b0, 1'b0, 8, 1'b0, 0, 0, 1'b0, cyc);
    check_line("odd_inv", ramp);

    // Floor of a negative sum, odd length right boundary
    host_write(0, -3);
    host_write(1, 0);
    host_write(2, 0);
    run_step(1'b0, 1'b1, 3, 1'b0, 0, 0, 1'b0, cyc);
    check_eq("floor_latency", cyc, 5);
    host_read(1, v);
    check_eq("floor_x1", v, 2);
    host_read(0, v);
    check_eq("floor_x0", v, -3);

    // Write coincident with start lands before the step reads it
    run_step(1'b0, 1'b1, 3, 1'b1, 2, 8, 1'b0, cyc);
    host_read(1, v);
    check_eq("coinc_x1", v, 0);
    host_read(2, v);
    check_eq("coinc_x2", v, 8);

    // Rejected lengths
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      len   = (k == 0) ? (AW+1)'(1) : (AW+1)'(257);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq($sformatf("bad_len%0d_err", k), int'(err), 1);
      check_eq($sformatf("bad_len%0d_busy", k), int'(busy), 0);
      @(posedge clk);
      #1;
      check_eq($sformatf("bad_len%0d_err_clr", k), int'(err), 0);
      check_eq($sformatf("bad_len%0d_busy2", k), int'(busy), 0);
    end
    host_read(0, v);
    check_eq("bad_len_x0", v, -3);
    host_read(1, v);
    check_eq("bad_len_x1", v, 0);
    host_read(2, v);
    check_eq("bad_len_x2", v, 8);

    // Reset after the first write of a len=8 forward predict
    for (int i = 0; i < 8; i++) host_write(i, 10 * i);
    @(negedge clk);
    pix_even_odd = 1'b0;
    pix_fwd_inv  = 1'b1;
    len          = (AW+1)'(8);
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_eq("midrst_no_done", dcount, 0);
    host_read(1, v);
    check_eq("midrst_x1", v, 0);
    host_read(3, v);
    check_eq("midrst_x3", v, 30);
    host_read(7, v);
    check_eq("midrst_x7", v, 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lift_step_ram.md
# lift_step_ram

Parametrised sample store for the 5/3 lifting wavelet path with a built-in, in-place lifting-step sequencer. A host loads one row or column of samples over a simple RAM port and issues `start`. The block then runs one predict (odd) or update (even) step, forward or inverse, over the stored line, using symmetric boundary extension. It replaces the fixed 256 x 17 even/odd RAM, whose left/sam/right neighbour addressing was driven externally; this block generates that addressing internally.

## Interface
Parameters:
- `W`, 17, signed sample width in bits.
- `AW`, 8, address width; depth = 2**AW samples.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pix_we`  in  1  host write strobe; honoured only when `busy`=0.
- `pix_addr`  in  AW  host read/write address.
- `pix_din`  in  W  host write data (signed).
- `pix_dout`  out  W  host read data; registered, 1-cycle latency.
- `pix_even_odd`  in  1  step select: 1 = update even samples, 0 = predict odd samples; sampled at `start`.
- `pix_fwd_inv`  in  1  1 = forward, 0 = inverse; sampled at `start`.
- `len`  in  AW+1  line length, 2..2**AW; sampled at `start`.
- `start`  in  1  one-cycle request; ignored while `busy`=1.
- `busy`  out  1  sequencer active.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
- Single-port synchronous-read RAM of 2**AW x W. Host owns the port when idle. Sequencer owns it when busy, and host writes are dropped.
- Targets: odd step uses i = 1,3,5,… < len (T = floor(len/2)). Even step uses i = 0,2,4,… < len (T = ceil(len/2)).
- Neighbours: L = x[i-1], with x[i+1] substituted when i=0. R = x[i+1], with x[i-1] substituted when i+1 ≥ len.
- Predict: x[i] ∓= (L+R)>>>1. Update: x[i] ±= (L+R+2)>>>2. Forward uses −predict, +update; inverse uses +predict, −update.
- Arithmetic: operands sign-extended to W+2 bits. Shift is arithmetic (floor). Result is truncated to W bits, wrapping with no saturation.
- FSM states: IDLE, RD_L, RD_C, RD_R, WR, DONE.
  - IDLE→RD_L: on `start` with a valid `len`.
  - RD_L: issue addr L.
  - RD_C: issue addr C; capture L.
  - RD_R: issue addr R; capture C.
  - WR: R is on RAM output; compute and write x[i].
  - WR→RD_L if more targets remain, else WR→DONE.
  - DONE→IDLE: `done` pulses.
- Invalid `len` (<2 or >2**AW): `err` pulses for one cycle, FSM stays in IDLE, RAM is untouched.
- Mode inputs and `len` are latched at start. Changes while busy have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `pix_dout`=0, FSM=IDLE, target index=0. RAM contents are not cleared.
- Host read: address at edge k, data on `pix_dout` after edge k+1. `pix_dout` holds its last value while busy.
- Start accepted at edge k: `busy`=1 from k+1; 4 cycles per target; last write at edge k+4T.
- At edge k+4T+1: `done`=1, `busy`=0. The host may start again in that same cycle.
- Reset asserted mid-step: returns to IDLE at the next edge, with no `done`. The RAM keeps any partial results.
- `start` coincident with `pix_we` when idle: the write is performed and the step starts on the next cycle.

## Structure
- Package `lift_pkg`:
  - FSM state enum.
  - Rounding constants (predict shift 1, update offset 2 / shift 2).
  - Default W/AW.
- Sub-module `lift_ram_sp`: parametrised single-port sync-read RAM.
- Top level: port mux, FSM, boundary address generator, arithmetic.

## Test plan
- Load ramp x[i]=10*i, len=8, forward odd step.
  - Required result: x1=x3=x5=0, x7=10; even samples unchanged.
  - `done` arrives 17 cycles after start.
- Follow with forward even step.
  - Required result: x0=0, x2=20, x4=40, x6=63.
- Inverse sequence: apply inverse even step then inverse odd step to the result of the previous scenario.
  - Required result: the exact ramp 0..70 is restored.
- Floor and sign: x0=−3, x1=0, x2=0, len=3, forward odd step.
  - Required result: x1=2.
- Rejected inputs:
  - len=1 or len=2**AW+1 → `err` pulse, `busy` stays 0, RAM unchanged.
  - `start` or `pix_we` during `busy` → ignored.
- Reset mid-run: assert `rst_n`=0 at cycle 5 of a len=8 step.
  - Required: `busy`=0 next cycle, no `done` pulse, and host reads return the partially updated data.
